// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, FSM state type and display record for the multiplexed
// seven-segment scan controller.
package seg_pkg;

  localparam int NDIG = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  // One complete display image: suppression flag, decimal points, hex digits
  typedef struct packed {
    logic            lz;
    logic [NDIG-1:0] dp;
    logic [4*NDIG-1:0] dig;
  } disp_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake and display drive bundle for the scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic            ld;
  logic            ld_rdy;
  logic [15:0]     din;
  logic [NDIG-1:0] dp_in;
  logic            lz_en;
  logic [NDIG-1:0] an;
  logic [6:0]      seg;
  logic            dp;

  modport master (
    output ld, din, dp_in, lz_en,
    input  ld_rdy, an, seg, dp
  );

  modport slave (
    input  ld, din, dp_in, lz_en,
    output ld_rdy, an, seg, dp
  );

endinterface

// File: rtl/seg_scan_ctrl_bin2seg.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module bin2seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Pure lookup; every nibble value maps to a glyph so no default path is needed
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a blanking gap at the
// start of each digit slot, a shadowed load port committed only at frame
// boundaries, and optional leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input logic            clk,
  input logic            rst_n,
  seg_scan_ctrl_if.slave bus
);
  import seg_pkg::*;

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  state_t          state_q, state_d;
  disp_t           disp_q, disp_d;
  disp_t           shadow_q, shadow_d;
  logic            pend_q, pend_d;
  logic            ldRdy_q, ldRdy_d;
  logic            frameEnd;
  logic [3:0]      nibSel;
  logic [6:0]      decSeg;
  logic            suppress;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  assign frameEnd = (idx_q == 2'd3) && (cnt_q == CNT_MAX);

  // Slot prescaler; the digit index steps whenever the prescaler wraps
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Load handshake: accept into the shadow, publish it only at the frame edge;
  // ready reasserts one edge after the commit because it follows old pending
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    disp_d   = disp_q;
    ldRdy_d  = ~pend_q;
    if (bus.ld && ldRdy_q) begin
      shadow_d = {bus.lz_en, bus.dp_in, bus.din};
      pend_d   = 1'b1;
      ldRdy_d  = 1'b0;
    end
    if (frameEnd && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

  // State register for the blank/show FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= seg_pkg::BLANK;
    else        state_q <= state_d;
  end

  // Next state: leave blanking once the slot reaches BLANK, re-enter on wrap
  always_comb begin
    state_d = state_q;
    case (state_q)
      seg_pkg::BLANK: if (cnt_d == CNT_BLANK) state_d = seg_pkg::SHOW;
      seg_pkg::SHOW:  if (cnt_d == '0)        state_d = seg_pkg::BLANK;
      default:        state_d = seg_pkg::BLANK;
    endcase
  end

  // Select the nibble for the upcoming digit and decide leading-zero blanking
  always_comb begin
    nibSel   = disp_d.dig[{idx_d, 2'b00} +: 4];
    suppress = 1'b0;
    case (idx_d)
      2'd3:    suppress = (disp_d.dig[15:12] == 4'h0);
      2'd2:    suppress = (disp_d.dig[15:8]  == 8'h00);
      2'd1:    suppress = (disp_d.dig[15:4]  == 12'h000);
      default: suppress = 1'b0;
    endcase
    suppress = suppress && disp_d.lz;
  end

  bin2seg u_bin2seg (
    .nib_i (nibSel),
    .seg_o (decSeg)
  );

  // Output decode from the post-edge state so registered pins match cnt/idx
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == seg_pkg::SHOW) begin
      an_d  = ~(NDIG'(1) << idx_d);
      seg_d = suppress ? SEG_OFF : decSeg;
      dp_d  = ~disp_d.dp[idx_d];
    end
  end

  // Counters, display image, shadow and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      ldRdy_q  <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      ldRdy_q  <= ldRdy_d;
    end
  end

  // Registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an     = an_q;
  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.ld_rdy = ldRdy_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The clock/reset scheme SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter DIV, default 50000, SHALL set the clock cycles per digit slot.
REQ-003 Parameter BLANK, default 500, SHALL set the blanking cycles at the start of each slot.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge system clock.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port ld, input, 1 bit, SHALL be the load request strobe.
REQ-007 Port ld_rdy, output, 1 bit, SHALL indicate that a load will be accepted.
REQ-008 Port din, input, 16 bits, SHALL carry four hex nibbles; din[3:0] is digit 0, the rightmost digit.
REQ-009 Port dp_in, input, 4 bits, SHALL carry the decimal-point request per digit, active-high.
REQ-010 Port lz_en, input, 1 bit, SHALL carry the leading-zero suppression enable, captured with din.
REQ-011 Port an, output, 4 bits, SHALL carry the digit anode enables, active-low.
REQ-012 Port seg, output, 7 bits, SHALL carry the segments {g,f,e,d,c,b,a}, active-low.
REQ-013 Port dp, output, 1 bit, SHALL carry the decimal-point segment, active-low.

Function
REQ-014 The prescaler cnt SHALL count 0..DIV-1 and wrap; the digit index idx (2 bits) SHALL advance 0->1->2->3->0 on the edge where cnt wraps.
REQ-015 The FSM SHALL have two states: BLANK while cnt<BLANK, and SHOW while BLANK<=cnt<=DIV-1.
REQ-016 In BLANK, an SHALL be 4'b1111, seg SHALL be 7'h7F and dp SHALL be 1.
REQ-017 In SHOW, an[idx] SHALL be 0 with all other an bits 1, and seg SHALL be the decoded nibble of digit idx from the display register.
REQ-018 In SHOW, dp SHALL be ~dp_reg[idx].
REQ-019 All outputs SHALL be registered, consistent with the post-edge cnt/idx values, and free of combinational paths from inputs.
REQ-020 A load SHALL be accepted when ld && ld_rdy at a rising edge; din, dp_in and lz_en SHALL then be captured into a shadow register, pending SHALL be set, and ld_rdy SHALL be driven 0.
REQ-021 A ld while ld_rdy=0 SHALL be ignored, with the shadow unchanged.
REQ-022 Commit SHALL occur only at the frame boundary, the edge where idx=3 and cnt=DIV-1: if pending, display <= shadow, pending SHALL be cleared, and ld_rdy SHALL return to 1 on the following edge.
REQ-023 A ld arriving on the commit edge SHALL be ignored, because ld_rdy is still 0 at that edge.
REQ-024 With lz_en=1, digit k (k=3..1) SHALL be blanked (seg=7'h7F, anode still driven) when nibbles k..3 are all zero.
REQ-025 Digit 0 SHALL never be suppressed, and dp SHALL still follow dp_reg during suppression.
REQ-026 The legal configuration SHALL be BLANK>=1 and DIV>=BLANK+2; other values are unsupported.

Reset
REQ-027 During and after rst_n=0, cnt, idx, display, shadow and pending SHALL be 0, the state SHALL be BLANK, an SHALL be 4'hF, seg SHALL be 7'h7F, dp SHALL be 1, and ld_rdy SHALL be 1.
REQ-028 Reset asserted mid-load or mid-frame SHALL discard any pending shadow.
REQ-029 After reset, the first slot SHALL show digit 0 as "0", with suppression off.

Structure
REQ-030 Package seg_pkg SHALL hold the constants NDIG=4 and SEG_OFF=7'h7F and the FSM state enum {BLANK, SHOW}.
REQ-031 The nibble-to-active-low-segment decode SHALL reuse the existing bin2seg decoder as the single sub-module instance.
REQ-032 The sub-module SHALL be fed by a mux on idx, with the suppression override applied after decode.

Verification (DIV=8, BLANK=2)
REQ-033 Reset release with no load: the bench SHALL see an cycle 1111,1111 (2 cycles), then 1110 for 6 cycles with seg=7'b1000000; slots SHALL repeat for idx 1..3 with seg=7'b1000000.
REQ-034 Load din=16'h1A2F, dp_in=4'b0100 mid-frame: ld_rdy SHALL go 0 and the display SHALL stay old until the frame boundary; the next frame SHALL show digits F,2,A,1 with dp=0 only in the digit-2 slot.
REQ-035 A second ld while pending, with din=16'hFFFF: it SHALL be ignored, and the frame after commit SHALL show 1A2F.
REQ-036 lz_en=1, din=16'h0005: digits 3..1 SHALL show seg=7'h7F with anodes active, and digit 0 SHALL show 7'b0010010.
REQ-037 lz_en=1, din=16'h0000: only digit 0 SHALL be lit, showing "0".
REQ-038 rst_n pulsed low while pending, with an asynchronous check: outputs SHALL go to reset values immediately, ld_rdy SHALL be 1, and the display SHALL be 0000.
